// File: rtl/ac_seq_pkg.sv
// Shared constants and strobe payload for the accumulator control sequencer.
// The optional I/O instruction group is enabled by defining AC_SEQ_IO_EN.
package ac_seq_pkg;

    localparam int unsigned AC_W   = 16;
    localparam int unsigned AC_SCW = 3;
    localparam int unsigned OPW    = 3;
    localparam int unsigned CSW    = 8;

    // Opcode field IR[W-2:W-4]
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_REG = 3'd7;

    // Register-reference bit positions within IR
    localparam int unsigned RR_CLA = 11;
    localparam int unsigned RR_CLE = 10;
    localparam int unsigned RR_CMA = 9;
    localparam int unsigned RR_CME = 8;
    localparam int unsigned RR_CIR = 7;
    localparam int unsigned RR_CIL = 6;
    localparam int unsigned RR_INC = 5;
    localparam int unsigned RR_SPA = 4;
    localparam int unsigned RR_SNA = 3;
    localparam int unsigned RR_SZA = 2;
    localparam int unsigned RR_SZE = 1;
    localparam int unsigned RR_HLT = 0;

    // I/O bit positions within IR
    localparam int unsigned IO_INP = 11;
    localparam int unsigned IO_OUT = 10;
    localparam int unsigned IO_SKI = 9;
    localparam int unsigned IO_SKO = 8;

    // ControlSig bit positions
    localparam int unsigned CS_AND  = 0;
    localparam int unsigned CS_ADD  = 1;
    localparam int unsigned CS_DR   = 2;
    localparam int unsigned CS_INPR = 3;
    localparam int unsigned CS_COM  = 4;
    localparam int unsigned CS_SHR  = 5;
    localparam int unsigned CS_SHL  = 6;
    localparam int unsigned CS_LD   = 7;

    // Sequence-counter T-states
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;

    typedef struct packed {
        logic [CSW-1:0] control_sig;
        logic           ar_ld_pc;
        logic           ar_ld_ir;
        logic           ar_ld_mem;
        logic           mem_rd;
        logic           mem_wr;
        logic           ir_ld;
        logic           dr_ld;
        logic           pc_inc;
        logic           pc_ld_ar;
        logic           e_clr;
        logic           e_cmp;
        logic           e_ld_co;
        logic           ac_inc;
    } strobe_t;

endpackage

// File: rtl/ac_seq_decode.sv
// Combinational T-state/opcode decode into datapath strobes and sequence control.
// The I/O group (opcode 7 with I=1) decodes INP only when AC_SEQ_IO_EN is defined.
module ac_seq_decode
    import ac_seq_pkg::*;
#(
    parameter int unsigned W   = AC_W,
    parameter int unsigned SCW = AC_SCW
) (
    input  logic           running,
    input  logic [SCW-1:0] sc,
    input  logic [W-2:0]   ir_body,
    input  logic           i_flag,
    input  logic           ac_sign,
    input  logic           ac_zero,
    input  logic           e_flag,
    output strobe_t        strobes_c,
    output logic           sc_clr_c,
    output logic           halt_c
);

    logic [OPW-1:0] opcode;

    assign opcode = ir_body[W-2:W-4];

    always_comb begin
        strobes_c = '0;
        sc_clr_c  = 1'b0;
        halt_c    = 1'b0;
        if (running) begin
            case (sc)
                SCW'(T0): strobes_c.ar_ld_pc = 1'b1;
                SCW'(T1): begin
                    strobes_c.mem_rd = 1'b1;
                    strobes_c.ir_ld  = 1'b1;
                    strobes_c.pc_inc = 1'b1;
                end
                SCW'(T2): strobes_c.ar_ld_ir = 1'b1;
                SCW'(T3): begin
                    if (opcode == OP_REG) begin
                        sc_clr_c = 1'b1;
                        if (!i_flag) begin
                            // AC operations are mutually exclusive by priority; E ops and skips are not
                            if (ir_body[RR_CLA]) begin
                                strobes_c.control_sig[CS_LD] = 1'b1;
                            end else if (ir_body[RR_CMA]) begin
                                strobes_c.control_sig[CS_LD]  = 1'b1;
                                strobes_c.control_sig[CS_COM] = 1'b1;
                            end else if (ir_body[RR_CIR]) begin
                                strobes_c.control_sig[CS_LD]  = 1'b1;
                                strobes_c.control_sig[CS_SHR] = 1'b1;
                            end else if (ir_body[RR_CIL]) begin
                                strobes_c.control_sig[CS_LD]  = 1'b1;
                                strobes_c.control_sig[CS_SHL] = 1'b1;
                            end else if (ir_body[RR_INC]) begin
                                strobes_c.ac_inc = 1'b1;
                            end
                            strobes_c.e_clr  = ir_body[RR_CLE];
                            strobes_c.e_cmp  = ir_body[RR_CME];
                            strobes_c.pc_inc = (ir_body[RR_SPA] & ~ac_sign & ~ac_zero)
                                             | (ir_body[RR_SNA] & ac_sign)
                                             | (ir_body[RR_SZA] & ac_zero)
                                             | (ir_body[RR_SZE] & ~e_flag);
                            halt_c = ir_body[RR_HLT];
                        end else begin
`ifdef AC_SEQ_IO_EN
                            // OUT/SKI/SKO are reserved and drive no AC strobe
                            if (ir_body[IO_INP]) begin
                                strobes_c.control_sig[CS_LD]   = 1'b1;
                                strobes_c.control_sig[CS_INPR] = 1'b1;
                            end
`endif
                        end
                    end else if (i_flag) begin
                        strobes_c.mem_rd    = 1'b1;
                        strobes_c.ar_ld_mem = 1'b1;
                    end
                end
                SCW'(T4): begin
                    case (opcode)
                        OP_AND, OP_ADD, OP_LDA: begin
                            strobes_c.mem_rd = 1'b1;
                            strobes_c.dr_ld  = 1'b1;
                        end
                        OP_STA: begin
                            strobes_c.mem_wr = 1'b1;
                            sc_clr_c         = 1'b1;
                        end
                        OP_BUN: begin
                            strobes_c.pc_ld_ar = 1'b1;
                            sc_clr_c           = 1'b1;
                        end
                        default: sc_clr_c = 1'b1;
                    endcase
                end
                SCW'(T5): begin
                    sc_clr_c = 1'b1;
                    strobes_c.control_sig[CS_LD] = 1'b1;
                    case (opcode)
                        OP_AND: strobes_c.control_sig[CS_AND] = 1'b1;
                        OP_ADD: begin
                            strobes_c.control_sig[CS_ADD] = 1'b1;
                            strobes_c.e_ld_co             = 1'b1;
                        end
                        OP_LDA: strobes_c.control_sig[CS_DR] = 1'b1;
                        default: strobes_c.control_sig[CS_LD] = 1'b0;
                    endcase
                end
                default: sc_clr_c = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ac_control_sequencer.sv
// Timing/decode sequencer: holds SC, IR, I and run flag S; strobes decode combinationally.
// Defining AC_SEQ_IO_EN enables the INP instruction of the I/O group.
module ac_control_sequencer
    import ac_seq_pkg::*;
#(
    parameter int unsigned W   = AC_W,
    parameter int unsigned SCW = AC_SCW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   mem_data,
    input  logic           ac_sign,
    input  logic           ac_zero,
    input  logic           e_flag,
    output logic [CSW-1:0] ControlSig,
    output logic           ar_ld_pc,
    output logic           ar_ld_ir,
    output logic           ar_ld_mem,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           ir_ld,
    output logic           dr_ld,
    output logic           pc_inc,
    output logic           pc_ld_ar,
    output logic           e_clr,
    output logic           e_cmp,
    output logic           e_ld_co,
    output logic           ac_inc,
    output logic           running
);

    logic [SCW-1:0] sc_q, sc_d;
    logic [W-1:0]   ir_q, ir_d;
    logic           i_q, i_d;
    logic           s_q, s_d;
    strobe_t        strobes_c;
    logic           sc_clr_c;
    logic           halt_c;

    ac_seq_decode #(
        .W   (W),
        .SCW (SCW)
    ) u_decode (
        .running   (s_q),
        .sc        (sc_q),
        .ir_body   (ir_q[W-2:0]),
        .i_flag    (i_q),
        .ac_sign   (ac_sign),
        .ac_zero   (ac_zero),
        .e_flag    (e_flag),
        .strobes_c (strobes_c),
        .sc_clr_c  (sc_clr_c),
        .halt_c    (halt_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q <= '0;
            ir_q <= '0;
            i_q  <= 1'b0;
            s_q  <= 1'b0;
        end else begin
            sc_q <= sc_d;
            ir_q <= ir_d;
            i_q  <= i_d;
            s_q  <= s_d;
        end
    end

    // Sequencing only advances while running; start is honoured only when halted
    always_comb begin
        sc_d = sc_q;
        ir_d = ir_q;
        i_d  = i_q;
        s_d  = s_q;
        if (!s_q) begin
            sc_d = '0;
            if (start) begin
                s_d = 1'b1;
            end
        end else begin
            if (strobes_c.ir_ld) begin
                ir_d = mem_data;
            end
            if (strobes_c.ar_ld_ir) begin
                i_d = ir_q[W-1];
            end
            sc_d = sc_clr_c ? '0 : SCW'(sc_q + SCW'(1));
            if (halt_c) begin
                s_d = 1'b0;
            end
        end
    end

    assign ControlSig = strobes_c.control_sig;
    assign ar_ld_pc   = strobes_c.ar_ld_pc;
    assign ar_ld_ir   = strobes_c.ar_ld_ir;
    assign ar_ld_mem  = strobes_c.ar_ld_mem;
    assign mem_rd     = strobes_c.mem_rd;
    assign mem_wr     = strobes_c.mem_wr;
    assign ir_ld      = strobes_c.ir_ld;
    assign dr_ld      = strobes_c.dr_ld;
    assign pc_inc     = strobes_c.pc_inc;
    assign pc_ld_ar   = strobes_c.pc_ld_ar;
    assign e_clr      = strobes_c.e_clr;
    assign e_cmp      = strobes_c.e_cmp;
    assign e_ld_co    = strobes_c.e_ld_co;
    assign ac_inc     = strobes_c.ac_inc;
    assign running    = s_q;

endmodule

// File: tb/tb_ac_control_sequencer.sv
// Directed scoreboard bench for ac_control_sequencer; per-cycle expected strobe words are
// queued per instruction and compared at each falling edge. Honors AC_SEQ_IO_EN.
module tb_ac_control_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mem_data;
    logic        ac_sign;
    logic        ac_zero;
    logic        e_flag;
    logic [7:0]  ControlSig;
    logic        ar_ld_pc, ar_ld_ir, ar_ld_mem, mem_rd, mem_wr, ir_ld, dr_ld;
    logic        pc_inc, pc_ld_ar, e_clr, e_cmp, e_ld_co, ac_inc, running;

    ac_control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_data   (mem_data),
        .ac_sign    (ac_sign),
        .ac_zero    (ac_zero),
        .e_flag     (e_flag),
        .ControlSig (ControlSig),
        .ar_ld_pc   (ar_ld_pc),
        .ar_ld_ir   (ar_ld_ir),
        .ar_ld_mem  (ar_ld_mem),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_ld      (ir_ld),
        .dr_ld      (dr_ld),
        .pc_inc     (pc_inc),
        .pc_ld_ar   (pc_ld_ar),
        .e_clr      (e_clr),
        .e_cmp      (e_cmp),
        .e_ld_co    (e_ld_co),
        .ac_inc     (ac_inc),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed word: {ControlSig, 13 strobes, running}
    logic [21:0] obs;
    assign obs = {ControlSig, ar_ld_pc, ar_ld_ir, ar_ld_mem, mem_rd, mem_wr, ir_ld,
                  dr_ld, pc_inc, pc_ld_ar, e_clr, e_cmp, e_ld_co, ac_inc, running};

    localparam logic [21:0] RUN    = 22'h000001;
    localparam logic [21:0] ACINC  = 22'h000002;
    localparam logic [21:0] ELDCO  = 22'h000004;
    localparam logic [21:0] ECMP   = 22'h000008;
    localparam logic [21:0] ECLR   = 22'h000010;
    localparam logic [21:0] PCLDAR = 22'h000020;
    localparam logic [21:0] PCINC  = 22'h000040;
    localparam logic [21:0] DRLD   = 22'h000080;
    localparam logic [21:0] IRLD   = 22'h000100;
    localparam logic [21:0] MWR    = 22'h000200;
    localparam logic [21:0] MRD    = 22'h000400;
    localparam logic [21:0] ARMEM  = 22'h000800;
    localparam logic [21:0] ARIR   = 22'h001000;
    localparam logic [21:0] ARPC   = 22'h002000;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [21:0] cs(input logic [7:0] v);
        return {v, 14'b0};
    endfunction

    task automatic chk(input string tag, input logic [21:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [21:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    // Pop one entry per falling edge until the scoreboard is empty
    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk(e.tag, e.v);
        end
    endtask

    task automatic push_fetch(input string tag);
        push({tag, ".T0"}, RUN | ARPC);
        push({tag, ".T1"}, RUN | MRD | IRLD | PCINC);
        push({tag, ".T2"}, RUN | ARIR);
    endtask

    // n_exec: 0 = ends at T3, 1 = ends at T4, 2 = ends at T5
    task automatic instr(input string tag, input logic [15:0] d, input logic [21:0] t3,
                         input int n_exec, input logic [21:0] t4, input logic [21:0] t5);
        mem_data = d;
        push_fetch(tag);
        push({tag, ".T3"}, RUN | t3);
        if (n_exec >= 1) push({tag, ".T4"}, RUN | t4);
        if (n_exec >= 2) push({tag, ".T5"}, RUN | t5);
        drain();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mem_data = 16'h0000;
        ac_sign  = 1'b0;
        ac_zero  = 1'b0;
        e_flag   = 1'b1;

        #2 chk("reset", 22'h0);
        start = 1'b1;
        @(posedge clk);
        #1 chk("reset_start_ignored", 22'h0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 22'h0);
        pulse_start();

        // Memory-reference group
        instr("ADD_dir", 16'h1005, 22'h0, 2, MRD | DRLD, cs(8'h82) | ELDCO);
        instr("AND_ind", 16'h8005, MRD | ARMEM, 2, MRD | DRLD, cs(8'h81));
        instr("LDA_dir", 16'h2010, 22'h0, 2, MRD | DRLD, cs(8'h84));
        instr("STA_dir", 16'h3010, 22'h0, 1, MWR, 22'h0);
        instr("BUN_dir", 16'h4010, 22'h0, 1, PCLDAR, 22'h0);
        instr("OP5_nop", 16'h5010, 22'h0, 1, 22'h0, 22'h0);

        // Register-reference group
        instr("CLA",     16'h7800, cs(8'h80), 0, 22'h0, 22'h0);
        instr("CLA_CMA", 16'h7A00, cs(8'h80), 0, 22'h0, 22'h0);
        instr("CMA",     16'h7200, cs(8'h90), 0, 22'h0, 22'h0);
        instr("CIR",     16'h7080, cs(8'hA0), 0, 22'h0, 22'h0);
        instr("CIL",     16'h7040, cs(8'hC0), 0, 22'h0, 22'h0);
        instr("CIR_INC", 16'h70A0, cs(8'hA0), 0, 22'h0, 22'h0);
        instr("INC",     16'h7020, ACINC, 0, 22'h0, 22'h0);
        instr("CLE_CME", 16'h7500, ECLR | ECMP, 0, 22'h0, 22'h0);
        ac_zero = 1'b1;
        instr("SZA_z1",  16'h7004, PCINC, 0, 22'h0, 22'h0);
        ac_zero = 1'b0;
        instr("SZA_z0",  16'h7004, 22'h0, 0, 22'h0, 22'h0);
        instr("SPA_pos", 16'h7010, PCINC, 0, 22'h0, 22'h0);
        ac_sign = 1'b1;
        instr("SPA_neg", 16'h7010, 22'h0, 0, 22'h0, 22'h0);
        instr("SNA_neg", 16'h7008, PCINC, 0, 22'h0, 22'h0);
        ac_sign = 1'b0;
        instr("SZE_e1",  16'h7002, 22'h0, 0, 22'h0, 22'h0);
        e_flag = 1'b0;
        instr("SZE_e0",  16'h7002, PCINC, 0, 22'h0, 22'h0);

`ifdef AC_SEQ_IO_EN
        instr("IO_INP",  16'hF800, cs(8'h88), 0, 22'h0, 22'h0);
`else
        instr("IO_INP",  16'hF800, 22'h0, 0, 22'h0, 22'h0);
`endif
        instr("IO_OUT",  16'hF400, 22'h0, 0, 22'h0, 22'h0);

        // HLT with start held high: halt must win, then outputs go quiet
        start = 1'b1;
        instr("HLT", 16'h7001, 22'h0, 0, 22'h0, 22'h0);
        start = 1'b0;
        push("halted0", 22'h0);
        push("halted1", 22'h0);
        drain();
        pulse_start();
        instr("resume_CLA", 16'h7800, cs(8'h80), 0, 22'h0, 22'h0);

        // Async reset during T4 of LDA
        mem_data = 16'h2010;
        push_fetch("LDA_rst");
        push("LDA_rst.T3", RUN);
        push("LDA_rst.T4", RUN | MRD | DRLD);
        drain();
        #2 rst = 1'b1;
        #1 chk("rst_midT4_immediate", 22'h0);
        @(negedge clk);
        rst = 1'b0;
        push("after_rst0", 22'h0);
        push("after_rst1", 22'h0);
        drain();
        pulse_start();
        instr("post_rst_ADD", 16'h1005, 22'h0, 2, MRD | DRLD, cs(8'h82) | ELDCO);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
